// File: rtl/platform_pkg.sv
// Shared defaults, state encoding and limits for the on-chip memory test platform.
package platform_pkg;

  localparam int              DEF_ADDR_W = 8;
  localparam int              DEF_DATA_W = 8;
  localparam logic [7:0]      DEF_SEED   = 8'hA5;
  localparam int              ERR_W      = 5;
  localparam logic [ERR_W-1:0] ERR_MAX   = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_READ    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/platform_bram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle latency).
module platform_bram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset on the array or read register so the tools map this onto block RAM.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/platform_top.sv
// Memory test platform: fills a RAM with addr^SEED, reads it back, counts mismatches,
// and reports write_done / read_done / pass / error count on the LEDs.
//
// state   | meaning
// IDLE    | waiting for the synchronised write request
// WRITE   | one RAM write per cycle while we_s is high
// WAIT_RD | write complete, waiting for the synchronised read request
// READ    | issue reads while re_s is high, compare returned words
// DONE    | both phases finished, status frozen until reset
module platform_top
  import platform_pkg::*;
#(
  parameter int              ADDR_W = DEF_ADDR_W,
  parameter int              DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED = DEF_SEED
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       read_enable,
  input  logic       write_enable,
  output logic [7:0] led
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  logic we_meta_q, we_s_q, re_meta_q, re_s_q;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic rd_vld_q, rd_vld_d;
  logic issue_done_q, issue_done_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic write_done_q, write_done_d;
  logic read_done_q, read_done_d;
  logic [7:0] led_q, led_d;
  logic ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  platform_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
    .clk   (sys_clk),
    .we    (ram_we),
    .waddr (addr_q),
    .wdata (ram_wdata),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_addr_d    = rd_addr_q;
    rd_vld_d     = 1'b0;
    issue_done_d = issue_done_q;
    err_cnt_d    = err_cnt_q;
    write_done_d = write_done_q;
    read_done_d  = read_done_q;
    ram_we       = 1'b0;
    ram_wdata    = DATA_W'(addr_q) ^ SEED;

    case (state_q)
      ST_IDLE: begin
        if (we_s_q) begin
          state_d = ST_WRITE;
          addr_d  = '0;
        end
      end
      ST_WRITE: begin
        if (we_s_q) begin
          ram_we = 1'b1;
          if (addr_q == ADDR_LAST) begin
            write_done_d = 1'b1;
            addr_d       = '0;
            state_d      = ST_WAIT_RD;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_WAIT_RD: begin
        if (re_s_q) begin
          state_d      = ST_READ;
          issue_done_d = 1'b0;
        end
      end
      ST_READ: begin
        if (re_s_q && !issue_done_q) begin
          rd_vld_d  = 1'b1;
          rd_addr_d = addr_q;
          if (addr_q == ADDR_LAST) issue_done_d = 1'b1;
          else                     addr_d = addr_q + ADDR_W'(1);
        end
        // rd_addr_q tags the word now on ram_rdata, issued one cycle earlier.
        if (rd_vld_q) begin
          if ((ram_rdata != (DATA_W'(rd_addr_q) ^ SEED)) && (err_cnt_q != ERR_MAX))
            err_cnt_d = err_cnt_q + ERR_W'(1);
          if (rd_addr_q == ADDR_LAST) begin
            read_done_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    led_d = {write_done_q, read_done_q, read_done_q & (err_cnt_q == '0), err_cnt_q};
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      we_meta_q    <= 1'b0;
      we_s_q       <= 1'b0;
      re_meta_q    <= 1'b0;
      re_s_q       <= 1'b0;
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rd_addr_q    <= '0;
      rd_vld_q     <= 1'b0;
      issue_done_q <= 1'b0;
      err_cnt_q    <= '0;
      write_done_q <= 1'b0;
      read_done_q  <= 1'b0;
      led_q        <= 8'h00;
    end else begin
      we_meta_q    <= write_enable;
      we_s_q       <= we_meta_q;
      re_meta_q    <= read_enable;
      re_s_q       <= re_meta_q;
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_vld_q     <= rd_vld_d;
      issue_done_q <= issue_done_d;
      err_cnt_q    <= err_cnt_d;
      write_done_q <= write_done_d;
      read_done_q  <= read_done_d;
      led_q        <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_platform_top.sv
// Self-checking bench for platform_top: scoreboarded write timing and final LED status.
module tb_platform_top;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       read_enable = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] led;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cyc_q[$];
  int exp_led_q[$];

  platform_top dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .led          (led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic do_reset();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    sys_rst      = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      chk("rst_led", led, 0);
    end
    sys_rst = 1'b1;
  endtask

  // Enable edge lands on the posedge following this negedge; count cycles from there.
  task automatic run_write(input int pause_at, input int pause_len, input int exp_cyc);
    int n;
    int seen;
    exp_cyc_q.push_back(exp_cyc);
    @(negedge sys_clk);
    write_enable = 1'b1;
    n = 0;
    seen = 0;
    while (n < 700 && seen == 0) begin
      @(negedge sys_clk);
      n++;
      if (pause_len > 0 && n == pause_at) write_enable = 1'b0;
      if (pause_len > 0 && n == pause_at + pause_len) write_enable = 1'b1;
      if (led[7]) seen = 1;
    end
    chk("wr_seen", seen, 1);
    chk("wr_cycles", n - 1, exp_cyc_q.pop_front());
    chk("wr_led", led, 8'h80);
  endtask

  task automatic run_read(input logic [7:0] exp_led);
    int n;
    int seen;
    exp_led_q.push_back(int'(exp_led));
    @(negedge sys_clk);
    read_enable = 1'b1;
    n = 0;
    seen = 0;
    while (n < 700 && seen == 0) begin
      @(negedge sys_clk);
      n++;
      if (led[6]) seen = 1;
    end
    chk("rd_seen", seen, 1);
    chk("rd_led", led, exp_led_q.pop_front());
  endtask

  task automatic corrupt(input int a);
    logic [7:0] av;
    av = a[7:0];
    dut.u_bram.mem_q[av] <= ~(av ^ 8'hA5);
  endtask

  initial begin
    #2;
    do_reset();
    repeat (10) @(negedge sys_clk);
    chk("idle_led", led, 0);

    // Read request without a prior write must be ignored; a later write still starts cleanly.
    do_reset();
    @(negedge sys_clk);
    read_enable = 1'b1;
    repeat (300) @(negedge sys_clk);
    chk("rd_before_wr", led, 0);
    read_enable = 1'b0;
    repeat (5) @(negedge sys_clk);
    run_write(0, 0, 259);
    run_read(8'hE0);

    // Normal run, then status must hold in DONE with enables dropped.
    do_reset();
    run_write(0, 0, 259);
    run_read(8'hE0);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("done_hold", led, 8'hE0);

    // 50-cycle pause mid-write delays completion by exactly 50 cycles.
    do_reset();
    run_write(100, 50, 309);
    run_read(8'hE0);

    // Two corrupted words.
    do_reset();
    run_write(0, 0, 259);
    @(negedge sys_clk);
    corrupt(3);
    corrupt(200);
    run_read(8'hC2);

    // Forty corrupted words saturate the error count.
    do_reset();
    run_write(0, 0, 259);
    @(negedge sys_clk);
    for (int i = 10; i < 50; i++) corrupt(i);
    run_read(8'hDF);

    // Reset mid-write: the next write restarts from address 0.
    do_reset();
    @(negedge sys_clk);
    write_enable = 1'b1;
    repeat (120) @(negedge sys_clk);
    do_reset();
    run_write(0, 0, 259);
    run_read(8'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
